// File: rtl/memstage_pkg.sv
// Shared types and lane-shaping helpers for the memory pipeline stage.
// Operation codes, FSM state encoding and byte-lane functions live here.
package memstage_pkg;

   localparam int WAIT_CNT_W = 8;

   typedef enum logic [3:0] {
      NONE = 4'd0,
      LB   = 4'd1,
      LBU  = 4'd2,
      LH   = 4'd3,
      LHU  = 4'd4,
      LW   = 4'd5,
      SB   = 4'd6,
      SH   = 4'd7,
      SW   = 4'd8,
      LL   = 4'd9,
      SC   = 4'd10
   } memop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_NONE = 2'd3
   } size_t;

   function automatic size_t op_size(input memop_t op);
      size_t sz;
      case (op)
         LB, LBU, SB:    sz = SZ_BYTE;
         LH, LHU, SH:    sz = SZ_HALF;
         LW, SW, LL, SC: sz = SZ_WORD;
         default:        sz = SZ_NONE;
      endcase
      return sz;
   endfunction

   function automatic logic is_store(input memop_t op);
      return (op == SB) || (op == SH) || (op == SW) || (op == SC);
   endfunction

   function automatic logic is_load(input memop_t op);
      return (op == LB) || (op == LBU) || (op == LH) || (op == LHU) ||
             (op == LW) || (op == LL);
   endfunction

   function automatic logic is_misaligned(input memop_t op, input logic [1:0] off);
      logic bad;
      case (op_size(op))
         SZ_HALF: bad = off[0];
         SZ_WORD: bad = (off != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

   function automatic logic [3:0] byte_enable(input memop_t op, input logic [1:0] off);
      logic [3:0] be;
      case (op_size(op))
         SZ_BYTE: be = 4'b0001 << off;
         SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
         SZ_WORD: be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

   // Stores place the datum on every lane it could occupy so the byte enables alone select it.
   function automatic logic [31:0] replicate_store(input memop_t op, input logic [31:0] data);
      logic [31:0] rep;
      case (op_size(op))
         SZ_BYTE: rep = {4{data[7:0]}};
         SZ_HALF: rep = {2{data[15:0]}};
         default: rep = data;
      endcase
      return rep;
   endfunction

   function automatic logic [31:0] lane_extract(input memop_t op, input logic [1:0] off,
                                                input logic [31:0] word);
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      logic [31:0] res;
      lane_b = word[{off, 3'b000} +: 8];
      lane_h = off[1] ? word[31:16] : word[15:0];
      case (op)
         LB:      res = {{24{lane_b[7]}}, lane_b};
         LBU:     res = {24'h000000, lane_b};
         LH:      res = {{16{lane_h[15]}}, lane_h};
         LHU:     res = {16'h0000, lane_h};
         default: res = word;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane shaping between the stage and the word-wide data bus:
// byte enables, replicated store data and extended load data.
module mem_lane_align
   import memstage_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  offset,
   input  logic [31:0] store_data,
   input  logic [31:0] load_word,
   output logic [3:0]  byte_en,
   output logic [31:0] bus_wdata,
   output logic [31:0] load_data
);

   memop_t op_e;

   assign op_e      = memop_t'(op);
   assign byte_en   = byte_enable(op_e, offset);
   assign bus_wdata = replicate_store(op_e, store_data);
   assign load_data = lane_extract(op_e, offset, load_word);

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: one outstanding data-bus access per accepted operation,
// with ack timeout. Define STAGE_MEMORY_LLBIT_EN to enable load-linked/store-conditional tracking.
module stage_memory
   import memstage_pkg::*;
#(
   parameter int AW          = 32,
   parameter int ACK_TIMEOUT = 255
)
(
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [3:0]    in_op,
   input  logic [AW-1:0] in_addr,
   input  logic [31:0]   in_wdata,
   output logic          in_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_rdata,
   output logic          out_error,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [3:0]    dmem_be,
   output logic [AW-1:0] dmem_addr,
   output logic [31:0]   dmem_wdata,
   input  logic          dmem_ack,
   input  logic [31:0]   dmem_rdata,
   output logic          llbit
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(ACK_TIMEOUT - 1);

   state_t                state_q;
   state_t                state_d;
   memop_t                op_q;
   logic [AW-1:0]         addr_q;
   logic [31:0]           wdata_q;
   logic [WAIT_CNT_W-1:0] wait_cnt_q;
   logic [31:0]           rdata_q;
   logic                  error_q;

   memop_t                in_op_e;
   logic                  xfer;
   logic                  misaligned_in;
   logic                  mem_op_in;
   logic                  sc_blocked;
   logic                  bus_start;
   logic                  timeout_hit;
   logic [3:0]            lane_be;
   logic [31:0]           lane_wdata;
   logic [31:0]           lane_rdata;
   logic [31:0]           ack_result;

   assign in_op_e       = memop_t'(in_op);
   assign xfer          = in_valid && (state_q == IDLE);
   assign misaligned_in = is_misaligned(in_op_e, in_addr[1:0]);
   assign mem_op_in     = (op_size(in_op_e) != SZ_NONE);
   assign bus_start     = mem_op_in && !misaligned_in && !sc_blocked;
   assign timeout_hit   = !dmem_ack && (wait_cnt_q == WAIT_LAST);
   assign ack_result    = is_load(op_q) ? lane_rdata : {31'd0, op_q == SC};

   mem_lane_align u_lane_align (
      .op         (op_q),
      .offset     (addr_q[1:0]),
      .store_data (wdata_q),
      .load_word  (dmem_rdata),
      .byte_en    (lane_be),
      .bus_wdata  (lane_wdata),
      .load_data  (lane_rdata)
   );

`ifdef STAGE_MEMORY_LLBIT_EN
   logic          llbit_q;
   logic [AW-3:0] ll_word_q;

   // A failed SC never reaches the bus; it completes immediately with a zero result.
   assign sc_blocked = (in_op_e == SC) && !llbit_q;
   assign llbit      = llbit_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         llbit_q   <= 1'b0;
         ll_word_q <= '0;
      end else if ((state_q == REQ) && dmem_ack) begin
         if (op_q == LL) begin
            llbit_q   <= 1'b1;
            ll_word_q <= addr_q[AW-1:2];
         end else if (op_q == SC) begin
            llbit_q <= 1'b0;
         end else if (is_store(op_q) && (addr_q[AW-1:2] == ll_word_q)) begin
            llbit_q <= 1'b0;
         end
      end
   end
`else
   assign sc_blocked = 1'b0;
   assign llbit      = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (xfer) state_d = bus_start ? REQ : RESP;
         REQ:  if (dmem_ack || timeout_hit) state_d = RESP;
         RESP: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Operation capture and result registers; the result is held untouched throughout RESP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q       <= NONE;
         addr_q     <= '0;
         wdata_q    <= '0;
         wait_cnt_q <= '0;
         rdata_q    <= '0;
         error_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (xfer) begin
                  op_q       <= in_op_e;
                  addr_q     <= in_addr;
                  wdata_q    <= in_wdata;
                  wait_cnt_q <= '0;
                  rdata_q    <= '0;
                  error_q    <= misaligned_in;
               end
            end
            REQ: begin
               if (dmem_ack) begin
                  rdata_q <= ack_result;
                  error_q <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 1'b1;
                  if (timeout_hit) error_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready   = (state_q == IDLE);
      out_valid  = (state_q == RESP);
      out_error  = (state_q == RESP) && error_q;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      dmem_be    = 4'b0000;
      dmem_addr  = '0;
      dmem_wdata = '0;
      if (state_q == REQ) begin
         dmem_req   = 1'b1;
         dmem_we    = is_store(op_q);
         dmem_be    = lane_be;
         dmem_addr  = {addr_q[AW-1:2], 2'b00};
         dmem_wdata = lane_wdata;
      end
   end

   assign out_rdata = rdata_q;

endmodule

// File: tb/tb_stage_memory.sv
// Scoreboard bench for stage_memory: randomized and directed operations against a
// word-level reference model, with a reactive data-bus responder.
module tb_stage_memory;
   import memstage_pkg::*;

   localparam int AW          = 32;
   localparam int ACK_TIMEOUT = 255;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic [3:0]    in_op = 4'd0;
   logic [AW-1:0] in_addr = '0;
   logic [31:0]   in_wdata = '0;
   logic          in_ready;
   logic          out_valid;
   logic          out_ready;
   logic [31:0]   out_rdata;
   logic          out_error;
   logic          dmem_req;
   logic          dmem_we;
   logic [3:0]    dmem_be;
   logic [AW-1:0] dmem_addr;
   logic [31:0]   dmem_wdata;
   logic          dmem_ack;
   logic [31:0]   dmem_rdata;
   logic          llbit;

   typedef struct {
      logic [31:0] rdata;
      logic        error;
      logic        llbit;
      logic        bus;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } exp_t;

   typedef struct {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_t;

   exp_t exp_q[$];
   bus_t bus_q[$];

   int   tests = 0;
   int   fails = 0;
   int   lat = 0;
   bit   ack_en = 1'b1;
   bit   stray_en = 1'b1;
   bit   hold_low = 1'b0;
   bit   m_llbit = 1'b0;
   logic [31:0] m_ll_addr = '0;

   stage_memory #(.AW(AW), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_op      (in_op),
      .in_addr    (in_addr),
      .in_wdata   (in_wdata),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_rdata  (out_rdata),
      .out_error  (out_error),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_be    (dmem_be),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ack   (dmem_ack),
      .dmem_rdata (dmem_rdata),
      .llbit      (llbit)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h100) return 32'h80112233;
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: the expected result of one operation from the architectural rules,
   // then present it to the DUT and wait for the transfer edge.
   task automatic applyStimulus(input memop_t op, input logic [31:0] addr,
                                input logic [31:0] wdata, input bit acked);
      exp_t        e;
      int          size;
      int          off;
      int          guard;
      bit          store;
      logic [31:0] v;
      e = '{default: '0};
      off   = int'(addr & 32'd3);
      store = (op == SB) || (op == SH) || (op == SW) || (op == SC);
      case (op)
         LB, LBU, SB:    size = 1;
         LH, LHU, SH:    size = 2;
         LW, SW, LL, SC: size = 4;
         default:        size = 0;
      endcase
      e.addr = addr & 32'hFFFF_FFFC;
      if (size == 0) begin
         e.bus = 1'b0;
      end else if ((off % size) != 0) begin
         e.error = 1'b1;
`ifdef STAGE_MEMORY_LLBIT_EN
      end else if ((op == SC) && !m_llbit) begin
         e.rdata = 32'd0;
`endif
      end else begin
         e.bus = 1'b1;
         e.we  = store;
         e.be  = (size == 1) ? 4'(1 << off) : (size == 2) ? 4'(3 << off) : 4'hF;
         e.wdata = (size == 1) ? (wdata & 32'hFF) * 32'h01010101 :
                   (size == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
         if (!acked) begin
            e.bus   = 1'b0;
            e.error = 1'b1;
         end else begin
            if (!store) begin
               v = mem_word(e.addr) >> (8 * off);
               if (size == 1) begin
                  v = v & 32'hFF;
                  if ((op == LB) && (v >= 32'd128)) v = v - 32'd256;
               end else if (size == 2) begin
                  v = v & 32'hFFFF;
                  if ((op == LH) && (v >= 32'd32768)) v = v - 32'd65536;
               end
               e.rdata = v;
            end else if (op == SC) begin
               e.rdata = 32'd1;
            end
`ifdef STAGE_MEMORY_LLBIT_EN
            if (op == LL) begin
               m_llbit   = 1'b1;
               m_ll_addr = e.addr;
            end else if (op == SC) begin
               m_llbit = 1'b0;
            end else if (store && (e.addr == m_ll_addr)) begin
               m_llbit = 1'b0;
            end
`endif
         end
      end
      e.llbit = m_llbit;
      guard = 0;
      while (!in_ready && guard < 2000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) begin
         tests++;
         fails++;
         $display("[TB] FAIL in_ready_wait: got 0, expected 1 within 2000 cycles");
      end else begin
         in_valid = 1'b1;
         in_op    = op;
         in_addr  = addr;
         in_wdata = wdata;
         exp_q.push_back(e);
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic waitDrain();
      int guard = 0;
      while ((exp_q.size() != 0 || !in_ready) && guard < 3000) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 3000) begin
         tests++;
         fails++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
   endtask

   // Data-bus responder with random latency; stray acks are thrown in while no request is up.
   initial begin
      bus_t b;
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         dmem_ack = 1'b0;
         if (dmem_req) begin
            if (ack_en) begin
               if (lat == 0) begin
                  dmem_ack   = 1'b1;
                  dmem_rdata = mem_word(dmem_addr);
                  b.we    = dmem_we;
                  b.be    = dmem_be;
                  b.addr  = dmem_addr;
                  b.wdata = dmem_wdata;
                  bus_q.push_back(b);
                  lat = $urandom_range(0, 3);
               end else begin
                  lat--;
               end
            end
         end else if (stray_en && ($urandom_range(0, 7) == 0)) begin
            dmem_ack   = 1'b1;
            dmem_rdata = $urandom;
         end
      end
   end

   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk); #1;
         out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Monitor: compares every presented response with the queue head, pops on handshake.
   initial begin
      exp_t e;
      bus_t b;
      forever begin
         @(negedge clk);
         if (reset && out_valid) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("[TB] FAIL unexpected_out_valid: got 1, expected 0");
            end else begin
               e = exp_q[0];
               checkOutput("out_rdata", out_rdata, e.rdata);
               checkOutput("out_error", out_error, e.error);
               checkOutput("llbit", llbit, e.llbit);
               checkOutput("in_ready_in_resp", in_ready, 0);
               checkOutput("dmem_req_in_resp", dmem_req, 0);
               if (out_ready) begin
                  if (e.bus) begin
                     if (bus_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("[TB] FAIL bus_access: got none, expected one");
                     end else begin
                        b = bus_q.pop_front();
                        checkOutput("dmem_we", b.we, e.we);
                        checkOutput("dmem_be", b.be, e.be);
                        checkOutput("dmem_addr", b.addr, e.addr);
                        if (e.we) checkOutput("dmem_wdata", b.wdata, e.wdata);
                     end
                  end else begin
                     checkOutput("no_bus_access", bus_q.size(), 0);
                     bus_q.delete();
                  end
                  void'(exp_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #3000000;
      fails++;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      memop_t      op;
      logic [31:0] addr;
      int          cnt;

      #12;
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_dmem_req", dmem_req, 0);
      checkOutput("reset_dmem_we", dmem_we, 0);
      checkOutput("reset_dmem_be", dmem_be, 0);
      checkOutput("reset_out_rdata", out_rdata, 0);
      checkOutput("reset_out_error", out_error, 0);
      checkOutput("reset_llbit", llbit, 0);
      checkOutput("reset_in_ready", in_ready, 1);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;

      lat = 0;
      applyStimulus(LB, 32'h103, 32'h0, 1'b1);
      checkOutput("lb_dmem_be", dmem_be, 4'b1000);
      checkOutput("lb_dmem_addr", dmem_addr, 32'h100);
      checkOutput("lb_valid_cycle1", out_valid, 0);
      @(posedge clk); #1;
      checkOutput("lb_valid_cycle2", out_valid, 1);
      checkOutput("lb_rdata", out_rdata, 32'hFFFFFF80);
      waitDrain();

      lat = 0;
      applyStimulus(SH, 32'h202, 32'h0000BEEF, 1'b1);
      checkOutput("sh_dmem_be", dmem_be, 4'b1100);
      checkOutput("sh_dmem_wdata", dmem_wdata, 32'hBEEFBEEF);
      checkOutput("sh_dmem_we", dmem_we, 1);
      waitDrain();

      applyStimulus(LW, 32'h101, 32'h0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("misaligned_no_req", dmem_req, 0);
         @(posedge clk); #1;
      end
      waitDrain();

      ack_en   = 1'b0;
      hold_low = 1'b1;
      @(posedge clk); #1;
      applyStimulus(LW, 32'h200, 32'h0, 1'b0);
      cnt = 0;
      while (dmem_req && cnt < 1000) begin
         cnt++;
         @(posedge clk); #1;
      end
      checkOutput("timeout_req_cycles", cnt, ACK_TIMEOUT);
      for (int i = 0; i < 5; i++) begin
         checkOutput("hold_out_valid", out_valid, 1);
         checkOutput("hold_out_error", out_error, 1);
         checkOutput("hold_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      hold_low = 1'b0;
      ack_en   = 1'b1;
      waitDrain();

      applyStimulus(LL, 32'h40, 32'h0, 1'b1);
      applyStimulus(SC, 32'h40, 32'h12345678, 1'b1);
      applyStimulus(LL, 32'h40, 32'h0, 1'b1);
      applyStimulus(SW, 32'h40, 32'hCAFEF00D, 1'b1);
      applyStimulus(SC, 32'h40, 32'h87654321, 1'b1);
      applyStimulus(NONE, 32'h44, 32'h0, 1'b1);
      waitDrain();

      for (int n = 0; n < 200; n++) begin
         op = memop_t'($urandom_range(0, 10));
         if ($urandom_range(0, 1) == 0) addr = 32'h40 + ($urandom_range(0, 3) << 2);
         else addr = $urandom_range(0, 255) << 2;
         if ($urandom_range(0, 1) == 0) addr = addr + $urandom_range(0, 3);
         applyStimulus(op, addr, $urandom, 1'b1);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end
      waitDrain();

      ack_en = 1'b0;
      in_valid = 1'b1;
      in_op    = LW;
      in_addr  = 32'h80;
      in_wdata = '0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checkOutput("pre_reset_req", dmem_req, 1);
      reset = 1'b0;
      #1;
      checkOutput("reset_mid_req_dmem_req", dmem_req, 0);
      checkOutput("reset_mid_req_in_ready", in_ready, 1);
      @(posedge clk); #1;
      checkOutput("reset_mid_req_out_valid", out_valid, 0);
      checkOutput("reset_mid_req_llbit", llbit, 0);
      reset   = 1'b1;
      m_llbit = 1'b0;
      ack_en  = 1'b1;
      @(posedge clk); #1;
      checkOutput("after_reset_out_valid", out_valid, 0);

      for (int n = 0; n < 20; n++) begin
         op = memop_t'($urandom_range(0, 10));
         addr = 32'h40 + ($urandom_range(0, 3) << 2);
         applyStimulus(op, addr, $urandom, 1'b1);
      end
      waitDrain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stage_memory.md
STAGE_MEMORY -- requirements
Module: stage_memory

Interface
REQ-001 Parameter AW, 32, byte-address width of in_addr and dmem_addr.
REQ-002 Parameter ACK_TIMEOUT, 255, max cycles waiting for dmem_ack before bus error (8-bit counter).
REQ-003 Ports, in order:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- in_valid  in  1  execute result presented.
- in_op  in  4  memop_t: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW, LL, SC.
- in_addr  in  AW  effective address (rs + sign_immed).
- in_wdata  in  32  store data (rt).
- in_ready  out  1  stage accepts in_valid this cycle.
- out_valid  out  1  result available.
- out_ready  in  1  downstream (writeback) accepts.
- out_rdata  out  32  aligned, extended load data; SC: 1/0 success.
- out_error  out  1  misaligned or bus-timeout error.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write.
- dmem_be  out  4  byte enables.
- dmem_addr  out  AW  word-aligned address (low 2 bits zero).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_ack  in  1  one-cycle completion.
- dmem_rdata  in  32  read word, valid with dmem_ack.
- llbit  out  1  load-linked flag.

Function
REQ-004 FSM states IDLE, REQ, RESP; encoding in package.
REQ-005 in_ready = 1 only in IDLE; transfer when in_valid & in_ready.
REQ-006 IDLE, transfer, in_op NONE: go RESP, out_rdata=0, no bus access, out_error=0.
REQ-007 IDLE, transfer, misaligned (H: addr[0]=1; W/LL/SC: addr[1:0]!=0): go RESP, out_error=1, no bus access, llbit unchanged.
REQ-008 IDLE, transfer, aligned memory op: latch op/addr/wdata, go REQ; dmem_req=1 from the next cycle until the ack cycle inclusive.
REQ-009 dmem_be: byte 1<<addr[1:0]; half addr[1]?1100:0011; word 1111; loads drive the same be.
REQ-010 dmem_wdata: SB {4{b}}, SH {2{h}}, SW/SC word.
REQ-011 REQ: dmem_ack captures lane-extracted data (LB/LH sign-, LBU/LHU zero-extended), go RESP; a 1-cycle access gives out_valid 2 cycles after transfer.
REQ-012 REQ: wait counter increments per non-ack cycle; reaching ACK_TIMEOUT drops dmem_req, sets out_error=1, goes RESP.
REQ-013 RESP: out_valid=1, outputs held stable until out_ready; then IDLE (in_ready next cycle).
REQ-014 dmem_ack outside REQ is ignored.
REQ-015 out_valid, dmem_req, out_error are 0 in IDLE and REQ except as stated.

Reset
REQ-016 reset low asynchronously forces IDLE, counter 0, out_valid=0, dmem_req=0, dmem_we=0, dmem_be=0, out_rdata=0, out_error=0, llbit=0; reset mid-REQ abandons access with no response.

Configuration
REQ-017 With STAGE_MEMORY_LLBIT_EN defined: LL sets llbit on ack; SW/SH/SB ack to the LL word address clears it; SC issues write only if llbit=1 (else no bus access, RESP, out_rdata=0), SC clears llbit.
REQ-018 Without it: llbit tied 0; LL behaves as LW; SC behaves as SW and returns out_rdata=1.

Structure
REQ-019 Package memstage_pkg: memop_t, state enum, lane-extract and byte-enable functions.
REQ-020 One sub-module mem_lane_align (combinational be/wdata/rdata shaping).

Verification
REQ-021 LB addr 0x103, rdata 0x80112233 ack 1 cycle -> be=1000, dmem_addr=0x100, out_rdata=0xFFFFFF80, out_valid at transfer+2.
REQ-022 SH addr 0x202, wdata 0x0000BEEF -> be=1100, dmem_wdata=0xBEEFBEEF, dmem_we=1.
REQ-023 LW addr 0x101 -> out_error=1, dmem_req never asserted.
REQ-024 No ack for ACK_TIMEOUT cycles -> dmem_req drops, out_error=1; out_ready low 5 cycles -> outputs hold, in_ready=0.
REQ-025 LLBIT_EN: LL 0x40, SC 0x40 -> write, out_rdata=1; LL 0x40, SW 0x40, SC 0x40 -> no write, out_rdata=0.
REQ-026 Reset asserted during REQ -> next cycle IDLE, dmem_req=0, no out_valid.
